// File: rtl/sync_ptr_multi.sv
// Multi-channel CDC receiver for async-FIFO gray pointers and status flags.
// Synchronizes, decodes gray->binary, computes fill level and flags incoherent gray steps.
module sync_ptr_multi #(
  parameter int AWIDTH      = 3,
  parameter int CHANNELS    = 2,
  parameter int SYNC_STAGES = 2,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                          clk_i,
  input  logic                          srst_n_i,
  input  logic [CHANNELS*(AWIDTH+1)-1:0] ptr_gray_async_i,
  input  logic [CHANNELS-1:0]           flag_async_i,
  input  logic [CHANNELS*(AWIDTH+1)-1:0] local_ptr_bin_i,
  input  logic                          err_clr_i,
  output logic [CHANNELS*(AWIDTH+1)-1:0] ptr_gray_o,
  output logic [CHANNELS*(AWIDTH+1)-1:0] ptr_bin_o,
  output logic [CHANNELS*(AWIDTH+1)-1:0] level_o,
  output logic [CHANNELS-1:0]           flag_o,
  output logic [CHANNELS-1:0]           flag_rise_o,
  output logic [CHANNELS-1:0]           gray_err_o,
  output logic [ERR_CNT_W-1:0]          err_cnt_o
);
  localparam int PW   = AWIDTH + 1;
  localparam int DW   = CHANNELS * PW;
  localparam int WARM = SYNC_STAGES + 1;
  localparam int WCW  = $clog2(WARM + 1);

  logic [SYNC_STAGES-1:0][DW-1:0]       ptr_sync_q, ptr_sync_d;
  logic [SYNC_STAGES-1:0][CHANNELS-1:0] flag_sync_q, flag_sync_d;
  logic [DW-1:0]          ptr_bin_q, ptr_bin_d;
  logic [DW-1:0]          level_q, level_d;
  logic [CHANNELS-1:0]    flag_prev_q, flag_prev_d;
  logic [CHANNELS-1:0]    flag_rise_q, flag_rise_d;
  logic [CHANNELS-1:0]    gray_err_q, gray_err_d;
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic [WCW-1:0]         warm_cnt_q, warm_cnt_d;
  logic [CHANNELS-1:0]    err_now;
  logic                   warm_active;
  logic [PW-1:0]          diff;
  logic [PW-1:0]          gray_ch;
  logic [PW-1:0]          bin_ch;

  always_comb begin
    ptr_sync_d     = ptr_sync_q;
    flag_sync_d    = flag_sync_q;
    ptr_sync_d[0]  = ptr_gray_async_i;
    flag_sync_d[0] = flag_async_i;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      ptr_sync_d[s]  = ptr_sync_q[s-1];
      flag_sync_d[s] = flag_sync_q[s-1];
    end

    // Checks stay masked until the chain holds only post-reset samples.
    warm_active = (warm_cnt_q < WCW'(WARM));
    warm_cnt_d  = warm_active ? warm_cnt_q + WCW'(1) : warm_cnt_q;

    diff      = '0;
    gray_ch   = '0;
    bin_ch    = '0;
    err_now   = '0;
    ptr_bin_d = '0;
    level_d   = '0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      // Compare the value about to enter the output stage with the one leaving it.
      diff = ptr_sync_q[SYNC_STAGES-2][ch*PW +: PW] ^ ptr_sync_q[SYNC_STAGES-1][ch*PW +: PW];
      err_now[ch] = !warm_active && ((diff & (diff - PW'(1))) != '0);

      gray_ch = ptr_sync_q[SYNC_STAGES-1][ch*PW +: PW];
      bin_ch[PW-1] = gray_ch[PW-1];
      for (int i = PW - 2; i >= 0; i--) begin
        bin_ch[i] = bin_ch[i+1] ^ gray_ch[i];
      end
      ptr_bin_d[ch*PW +: PW] = bin_ch;
      level_d[ch*PW +: PW]   = ptr_bin_q[ch*PW +: PW] - local_ptr_bin_i[ch*PW +: PW];
    end

    flag_prev_d = flag_sync_q[SYNC_STAGES-1];
    flag_rise_d = warm_active ? '0 : (flag_sync_q[SYNC_STAGES-1] & ~flag_prev_q);

    gray_err_d = err_clr_i ? err_now : (gray_err_q | err_now);

    err_cnt_d = err_cnt_q;
    if (err_clr_i) begin
      err_cnt_d = ERR_CNT_W'(|err_now);
    end else if ((|err_now) && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      ptr_sync_q  <= '0;
      flag_sync_q <= '0;
      ptr_bin_q   <= '0;
      level_q     <= '0;
      flag_prev_q <= '0;
      flag_rise_q <= '0;
      gray_err_q  <= '0;
      err_cnt_q   <= '0;
      warm_cnt_q  <= '0;
    end else begin
      ptr_sync_q  <= ptr_sync_d;
      flag_sync_q <= flag_sync_d;
      ptr_bin_q   <= ptr_bin_d;
      level_q     <= level_d;
      flag_prev_q <= flag_prev_d;
      flag_rise_q <= flag_rise_d;
      gray_err_q  <= gray_err_d;
      err_cnt_q   <= err_cnt_d;
      warm_cnt_q  <= warm_cnt_d;
    end
  end

  assign ptr_gray_o  = ptr_sync_q[SYNC_STAGES-1];
  assign flag_o      = flag_sync_q[SYNC_STAGES-1];
  assign ptr_bin_o   = ptr_bin_q;
  assign level_o     = level_q;
  assign flag_rise_o = flag_rise_q;
  assign gray_err_o  = gray_err_q;
  assign err_cnt_o   = err_cnt_q;
endmodule

// File: tb/tb_sync_ptr_multi.sv
// Bench for sync_ptr_multi: delay-history model compared every cycle, plus
// directed scenarios with literal expectations (a second instance uses a 2-bit counter).
module tb_sync_ptr_multi;
  logic       clk = 1'b0;
  logic       srst_n;
  logic [7:0] ptr_in, local_in;
  logic [1:0] flag_in;
  logic       clr;

  logic [7:0] gray_o, bin_o, level_o, cnt_o;
  logic [1:0] flag_o, rise_o, gerr_o;
  logic [7:0] s_gray_o, s_bin_o, s_level_o;
  logic [1:0] s_flag_o, s_rise_o, s_gerr_o, s_cnt_o;

  int checks   = 0;
  int failures = 0;

  // Model state: history of inputs per edge (index 0 = newest)
  logic [7:0] hp[4];
  logic [1:0] hf[4];
  int         k;
  logic       model_valid = 1'b0;
  logic [7:0] exp_gray, exp_bin, exp_level, exp_cnt;
  logic [1:0] exp_flag, exp_rise, exp_gerr, exp_sat;

  always #5 clk = ~clk;

  sync_ptr_multi dut (
    .clk_i(clk), .srst_n_i(srst_n), .ptr_gray_async_i(ptr_in), .flag_async_i(flag_in),
    .local_ptr_bin_i(local_in), .err_clr_i(clr), .ptr_gray_o(gray_o), .ptr_bin_o(bin_o),
    .level_o(level_o), .flag_o(flag_o), .flag_rise_o(rise_o), .gray_err_o(gerr_o),
    .err_cnt_o(cnt_o)
  );

  sync_ptr_multi #(.ERR_CNT_W(2)) dut_sat (
    .clk_i(clk), .srst_n_i(srst_n), .ptr_gray_async_i(ptr_in), .flag_async_i(flag_in),
    .local_ptr_bin_i(local_in), .err_clr_i(clr), .ptr_gray_o(s_gray_o), .ptr_bin_o(s_bin_o),
    .level_o(s_level_o), .flag_o(s_flag_o), .flag_rise_o(s_rise_o), .gray_err_o(s_gerr_o),
    .err_cnt_o(s_cnt_o)
  );

  function automatic logic [3:0] g2b(input logic [3:0] g);
    return g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One clock: sample inputs, advance the model on the edge, return at negedge.
  task automatic tick();
    logic [7:0] p, l;
    logic [1:0] f, e;
    logic       r, c, warm;
    p = ptr_in; l = local_in; f = flag_in; r = !srst_n; c = clr;
    @(posedge clk);
    if (r) begin
      for (int j = 0; j < 4; j++) begin
        hp[j] = '0;
        hf[j] = '0;
      end
      k = 0;
      exp_gray = '0; exp_bin = '0; exp_level = '0; exp_cnt = '0;
      exp_flag = '0; exp_rise = '0; exp_gerr = '0; exp_sat = '0;
    end else begin
      for (int j = 3; j > 0; j--) begin
        hp[j] = hp[j-1];
        hf[j] = hf[j-1];
      end
      hp[0] = p;
      hf[0] = f;
      warm = (k < 3);
      if (k < 3) k++;
      exp_gray = hp[1];
      e = '0;
      for (int ch = 0; ch < 2; ch++) begin
        exp_bin[ch*4 +: 4]   = g2b(hp[2][ch*4 +: 4]);
        exp_level[ch*4 +: 4] = g2b(hp[3][ch*4 +: 4]) - l[ch*4 +: 4];
        e[ch] = !warm && ($countones(hp[1][ch*4 +: 4] ^ hp[2][ch*4 +: 4]) > 1);
      end
      exp_gerr = c ? e : (exp_gerr | e);
      if (c) begin
        exp_cnt = {7'd0, |e};
        exp_sat = {1'b0, |e};
      end else if (|e) begin
        if (exp_cnt < 8'd255) exp_cnt++;
        if (exp_sat < 2'd3) exp_sat++;
      end
      exp_flag = hf[1];
      exp_rise = warm ? 2'b00 : (hf[2] & ~hf[3]);
    end
    model_valid = 1'b1;
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (model_valid) begin
      check("gray", gray_o, exp_gray);
      check("bin", bin_o, exp_bin);
      check("level", level_o, exp_level);
      check("flag", flag_o, exp_flag);
      check("rise", rise_o, exp_rise);
      check("gerr", gerr_o, exp_gerr);
      check("cnt", cnt_o, exp_cnt);
      check("s_gray", s_gray_o, exp_gray);
      check("s_level", s_level_o, exp_level);
      check("s_rise", s_rise_o, exp_rise);
      check("s_gerr", s_gerr_o, exp_gerr);
      check("s_cnt", s_cnt_o, exp_sat);
    end
  end

  initial begin
    srst_n = 1'b0; ptr_in = 8'hFF; flag_in = 2'b11; local_in = 8'h00; clr = 1'b0;
    // Reset with all-ones inputs
    tick(); tick();
    check("t1_rst_gray", gray_o, 8'h00);
    check("t1_rst_flag", flag_o, 2'b00);
    check("t1_rst_gerr", gerr_o, 2'b00);
    check("t1_rst_cnt", cnt_o, 8'h00);
    srst_n = 1'b1;
    tick();
    check("t1_gray_e1", gray_o, 8'h00);
    tick();
    check("t1_gray_e2", gray_o, 8'hFF);
    check("t1_flag_e2", flag_o, 2'b11);
    tick();
    check("t1_warm_rise", rise_o, 2'b00);
    check("t1_warm_gerr", gerr_o, 2'b00);

    // Fresh start with zero inputs
    srst_n = 1'b0; ptr_in = 8'h00; flag_in = 2'b00;
    tick(); tick();
    srst_n = 1'b1;
    repeat (4) tick();

    // Latency of gray, binary and level
    ptr_in = 8'h01;
    tick(); tick();
    check("t2_gray", gray_o, 8'h01);
    tick();
    check("t2_bin", bin_o, 8'h01);
    tick();
    check("t2_level", level_o, 8'h01);

    // Pointer walk through wrap with local pointer 14
    local_in = 8'h0E;
    for (int b = 2; b < 16; b++) begin
      ptr_in = {4'h0, 4'(b ^ (b >> 1))};
      tick();
    end
    repeat (4) tick();
    check("t3_gray15", gray_o, 8'h08);
    check("t3_level15", level_o, 8'h01);
    ptr_in = 8'h00;
    repeat (4) tick();
    check("t3_level0", level_o, 8'h02);
    check("t3_gerr", gerr_o, 2'b00);

    // Coherency errors
    local_in = 8'h00;
    ptr_in = 8'h30;
    tick(); tick();
    check("t4_gerr_ch1", gerr_o, 2'b10);
    check("t4_cnt1", cnt_o, 8'd1);
    tick();
    ptr_in = 8'hC7;
    tick(); tick();
    check("t4_gerr_both", gerr_o, 2'b11);
    check("t4_cnt2", cnt_o, 8'd2);
    tick();
    clr = 1'b1; tick(); clr = 1'b0;
    check("t4_clr_gerr", gerr_o, 2'b00);
    check("t4_clr_cnt", cnt_o, 8'd0);
    ptr_in = 8'hC0;
    tick();
    clr = 1'b1; tick(); clr = 1'b0;
    check("t4_clrerr_gerr", gerr_o, 2'b01);
    check("t4_clrerr_cnt", cnt_o, 8'd1);

    // Saturation: five consecutive error cycles
    clr = 1'b1; tick(); clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ptr_in[3:0] = (i % 2 == 0) ? 4'b0111 : 4'b0000;
      tick();
    end
    repeat (3) tick();
    check("t5_cnt", cnt_o, 8'd5);
    check("t5_sat", s_cnt_o, 2'd3);
    repeat (2) tick();
    check("t5_sat_hold", s_cnt_o, 2'd3);

    // Flag rise pulse, then mid-stream reset
    flag_in = 2'b01;
    tick(); tick();
    check("t6_flag", flag_o, 2'b01);
    check("t6_rise_early", rise_o, 2'b00);
    tick();
    check("t6_rise", rise_o, 2'b01);
    tick();
    check("t6_rise_end", rise_o, 2'b00);
    srst_n = 1'b0;
    tick();
    check("t6_rst_gray", gray_o, 8'h00);
    check("t6_rst_bin", bin_o, 8'h00);
    check("t6_rst_flag", flag_o, 2'b00);
    check("t6_rst_gerr", gerr_o, 2'b00);
    check("t6_rst_cnt", cnt_o, 8'h00);
    srst_n = 1'b1;
    repeat (5) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
